// File: rtl/universal_shift_reg.sv
//------------------------------------------------------------------------------
// Module      : universal_shift_reg
// Description : Universal shift register (hold / shift right / shift left /
//               parallel load) with a word-completion shift counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] out,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [1:0]       c_MODE_HOLD  = 2'b00;
  localparam logic [1:0]       c_MODE_RIGHT = 2'b01;
  localparam logic [1:0]       c_MODE_LEFT  = 2'b10;
  localparam logic [1:0]       c_MODE_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_shift;

  assign w_shift = en && ((mode == c_MODE_RIGHT) || (mode == c_MODE_LEFT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en) begin
        case (mode)
          c_MODE_RIGHT: r_out <= {sin_r, r_out[WIDTH-1:1]};
          c_MODE_LEFT:  r_out <= {r_out[WIDTH-2:0], sin_l};
          c_MODE_LOAD:  r_out <= data;
          c_MODE_HOLD:  r_out <= r_out;
          default:      r_out <= r_out;
        endcase
      end
      // Both shift directions share one counter; a load restarts the word.
      if (w_shift) begin
        if (r_cnt == c_CNT_LAST) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (en && (mode == c_MODE_LOAD)) begin
        r_cnt <= '0;
      end
    end
  end

  assign out       = r_out;
  assign shift_cnt = r_cnt;
  assign word_done = r_done;
  assign sout_r    = r_out[0];
  assign sout_l    = r_out[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
//------------------------------------------------------------------------------
// Module      : tb_universal_shift_reg
// Description : Self-checking bench for universal_shift_reg against a
//               behavioural integer model (WIDTH=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_universal_shift_reg;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [W-1:0]  data;
  logic          sin_r;
  logic          sin_l;
  logic [W-1:0]  out;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] shift_cnt;
  logic          word_done;

  int checks = 0;
  int errors = 0;

  // Model: register value as an integer, shifts counted since load/reset.
  int m_out  = 0;
  int m_cnt  = 0;
  int m_done = 0;

  universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data(data),
    .sin_r(sin_r), .sin_l(sin_l), .out(out), .sout_r(sout_r),
    .sout_l(sout_l), .shift_cnt(shift_cnt), .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_out = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_edge(input int e, input int md, input int d, input int sr, input int sl);
    m_done = 0;
    if (e != 0) begin
      if (md == 1 || md == 2) begin
        if (md == 1) m_out = m_out / 2 + sr * (1 << (W - 1));
        else         m_out = (m_out * 2 + sl) % (1 << W);
        m_cnt  = (m_cnt + 1) % W;
        m_done = (m_cnt == 0) ? 1 : 0;
      end else if (md == 3) begin
        m_out = d;
        m_cnt = 0;
      end
    end
  endtask

  // Apply one command, take one rising edge, advance the model, settle.
  task automatic drive_edge(input logic e, input logic [1:0] md, input logic [W-1:0] d,
                            input logic sr, input logic sl);
    en = e; mode = md; data = d; sin_r = sr; sin_l = sl;
    @(posedge clk);
    model_edge(int'(e), int'(md), int'(d), int'(sr), int'(sl));
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      drive_edge(1'b1, 2'($urandom_range(3)), 4'($urandom), 1'($urandom), 1'($urandom));
    pulse_reset();
    checks++;
    if (out !== 4'b0000 || shift_cnt !== 3'd0 || word_done !== 1'b0 ||
        sout_r !== 1'b0 || sout_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%b cnt=%0d done=%b sr=%b sl=%b, want 0000/0/0/0/0",
               out, shift_cnt, word_done, sout_r, sout_l);
    end
    // Inputs are ignored while reset is held across edges.
    en = 1'b1; mode = 2'b11; data = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 4'b0000 || shift_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: out=%b cnt=%0d, want 0000/0", out, shift_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    drive_edge(1'b1, 2'b11, 4'b1011, 1'b0, 1'b0);
    checks++;
    if (out !== 4'b1011 || shift_cnt !== 3'd0 || sout_r !== 1'b1 || sout_l !== 1'b1 ||
        word_done !== 1'b0) begin
      errors++;
      $display("FAIL load: out=%b cnt=%0d sr=%b sl=%b done=%b, want 1011/0/1/1/0",
               out, shift_cnt, sout_r, sout_l, word_done);
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_sout = 4'b1011;  // sout_r before edges 1..4 = 1,1,0,1
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sout_r !== exp_sout[i]) begin
        errors++;
        $display("FAIL shr_sout[%0d]: got %b want %b", i, sout_r, exp_sout[i]);
      end
      drive_edge(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (shift_cnt !== 3'((i + 1) % 4) || word_done !== (i == 3)) begin
        errors++;
        $display("FAIL shr_cnt[%0d]: cnt=%0d done=%b want %0d/%b",
                 i, shift_cnt, word_done, (i + 1) % 4, (i == 3));
      end
    end
    checks++;
    if (out !== 4'b0000) begin
      errors++;
      $display("FAIL shr_out: got %b want 0000", out);
    end
  endtask

  task automatic test_shift_left_load();
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1);
      checks++;
      if (word_done !== 1'b0) begin
        errors++;
        $display("FAIL shl_done[%0d]: got %b want 0", i, word_done);
      end
    end
    checks++;
    if (out !== 4'b0111 || shift_cnt !== 3'd3) begin
      errors++;
      $display("FAIL shl_out: out=%b cnt=%0d want 0111/3", out, shift_cnt);
    end
    drive_edge(1'b1, 2'b11, 4'b0101, 1'b0, 1'b0);
    checks++;
    if (out !== 4'b0101 || shift_cnt !== 3'd0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_load: out=%b cnt=%0d done=%b want 0101/0/0", out, shift_cnt, word_done);
    end
  endtask

  task automatic test_enable();
    logic [W-1:0]  s_out;
    logic [CW-1:0] s_cnt;
    drive_edge(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
    drive_edge(1'b1, 2'b10, 4'b0000, 1'b0, 1'b0);
    s_out = out; s_cnt = shift_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_edge(1'b0, (i < 3) ? 2'b01 : 2'b11, 4'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (out !== s_out || shift_cnt !== s_cnt || word_done !== 1'b0 ||
          out !== 4'(m_out) || shift_cnt !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL freeze[%0d]: out=%b cnt=%0d done=%b want %b/%0d/0",
                 i, out, shift_cnt, word_done, 4'(m_out), m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    drive_edge(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
    drive_edge(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
    pulse_reset();
    checks++;
    if (out !== 4'b0000 || shift_cnt !== 3'd0) begin
      errors++;
      $display("FAIL midword_rst: out=%b cnt=%0d want 0000/0", out, shift_cnt);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1);
      checks++;
      if (word_done !== (i == 3) || shift_cnt !== 3'((i + 1) % 4)) begin
        errors++;
        $display("FAIL midword_shift[%0d]: cnt=%0d done=%b want %0d/%b",
                 i, shift_cnt, word_done, (i + 1) % 4, (i == 3));
      end
    end
    checks++;
    if (out !== 4'b1111) begin
      errors++;
      $display("FAIL midword_out: got %b want 1111", out);
    end
  endtask

  task automatic test_back_to_back();
    drive_edge(1'b1, 2'b11, 4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive_edge(1'b1, ($urandom_range(1) != 0) ? 2'b01 : 2'b10, 4'b0000,
                 1'($urandom), 1'($urandom));
      checks++;
      if (word_done !== ((i % 4) == 3) || out !== 4'(m_out)) begin
        errors++;
        $display("FAIL b2b[%0d]: done=%b out=%b want %b/%b",
                 i, word_done, out, ((i % 4) == 3), 4'(m_out));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_edge(($urandom_range(7) != 0), 2'($urandom_range(3)), 4'($urandom),
                 1'($urandom), 1'($urandom));
      if ($urandom_range(24) == 0) begin
        pulse_reset();
        #1 rst_n = 1'b1;
      end
      checks++;
      if (out !== 4'(m_out) || shift_cnt !== 3'(m_cnt) || word_done !== (m_done != 0) ||
          sout_r !== 1'(m_out % 2) || sout_l !== 1'(m_out / (1 << (W - 1)))) begin
        errors++;
        $display("FAIL random[%0d]: out=%b cnt=%0d done=%b sr=%b sl=%b want %b/%0d/%0d",
                 i, out, shift_cnt, word_done, sout_r, sout_l, 4'(m_out), m_cnt, m_done);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; data = '0; sin_r = 1'b0; sin_l = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left_load();
    test_enable();
    test_reset_mid_word();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
